// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Issue stage in front of the datapath ALU. Accepts one decoded operation
//   over a valid/ready handshake and registers the ALU control code and both
//   operands at accept. One cycle later it captures the ALU result and zero
//   flag. It then presents result, branch decision and illegal flag
//   downstream over a second valid/ready handshake.
//
// Ports
//   clock, reset_n       rising-edge clock, async active-low reset
//   in_valid / in_ready  upstream handshake
//   ALUOp, funct3,       decoded instruction fields
//   funct7_5, ALUSrc
//   rs1_data, rs2_data,  operand sources
//   imm
//   alu_control,         registered drive to the ALU
//   alu_in1, alu_in2
//   alu_out, alu_zero    combinational ALU response
//   out_valid/out_ready  downstream handshake
//   result,              captured outputs, held while out_valid is high
//   branch_taken,
//   illegal
//   issued_count         completed downstream handshakes (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operation, in_ready=1
// EXEC  | operands are on the ALU, capture its result this cycle
// DONE  | result presented, waiting for out_ready (may accept next op)

module alu_issue_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  // Undecodable ops park the ALU on the all-zero code.
  localparam logic [3:0] CTRL_NONE = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] in1_q, in2_q;
  logic             pend_ill_q, pend_beq_q, pend_bne_q;
  logic [WIDTH-1:0] result_q;
  logic             br_q, ill_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_ctrl;
  logic       dec_ill, dec_beq, dec_bne;
  logic       accept, complete;

  // Instruction decode
  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_ill  = 1'b0;
    dec_beq  = 1'b0;
    dec_bne  = 1'b0;
    case (ALUOp)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: begin
        dec_ctrl = CTRL_SUB;
        case (funct3)
          3'b000:  dec_beq = 1'b1;
          3'b001:  dec_bne = 1'b1;
          default: begin
            dec_ill  = 1'b1;
            dec_ctrl = CTRL_NONE;
          end
        endcase
      end
      2'b10: begin
        case (funct3)
          // SUB only for the register form; the immediate form has no SUBI.
          3'b000:  dec_ctrl = (funct7_5 && !ALUSrc) ? CTRL_SUB : CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          3'b010:  dec_ctrl = CTRL_SLT;
          default: begin
            dec_ill  = 1'b1;
            dec_ctrl = CTRL_NONE;
          end
        endcase
      end
      default: begin
        dec_ill  = 1'b1;
        dec_ctrl = CTRL_NONE;
      end
    endcase
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_DONE;
      S_DONE: begin
        // The result slot frees as it is consumed, so a new op can be taken
        // in the same cycle.
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign complete = (state_q == S_DONE) && out_ready;
  assign cnt_d    = complete ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue registers: loaded only on accept, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= CTRL_NONE;
      in1_q      <= '0;
      in2_q      <= '0;
      pend_ill_q <= 1'b0;
      pend_beq_q <= 1'b0;
      pend_bne_q <= 1'b0;
    end else if (accept) begin
      ctrl_q     <= dec_ctrl;
      in1_q      <= rs1_data;
      in2_q      <= ALUSrc ? imm : rs2_data;
      pend_ill_q <= dec_ill;
      pend_beq_q <= dec_beq;
      pend_bne_q <= dec_bne;
    end
  end

  // Result registers: loaded in EXEC only, so they hold through DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_out;
      br_q     <= (pend_beq_q && alu_zero) || (pend_bne_q && !alu_zero);
      ill_q    <= pend_ill_q;
    end
  end

  assign alu_control  = ctrl_q;
  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign branch_taken = br_q;
  assign illegal      = ill_q;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUOp = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        ALUSrc = 1'b0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken, illegal;
  logic [15:0] issued_count;

  always #5 clock = ~clock;

  alu_issue_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .ALUSrc(ALUSrc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .illegal(illegal),
    .issued_count(issued_count)
  );

  // Environment: the datapath ALU driven by the unit.
  always_comb begin
    case (alu_control)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_in1 | alu_in2);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        br;
    logic        ill;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: what the operation means, expressed as plain arithmetic.
  task automatic ref_model(inout vec_t v);
    logic [31:0] b;
    b = v.src ? v.imm : v.rs2;
    v.br = 1'b0; v.ill = 1'b0;
    if (v.aluop == 2'b00) begin
      v.ctrl = 4'b0010; v.res = v.rs1 + b;
    end else if (v.aluop == 2'b01 && (v.f3 == 3'd0 || v.f3 == 3'd1)) begin
      v.ctrl = 4'b0110; v.res = v.rs1 - b;
      v.br = (v.f3 == 3'd0) ? (v.rs1 == b) : (v.rs1 != b);
    end else if (v.aluop == 2'b10 && v.f3 == 3'd0) begin
      if (v.f7 && !v.src) begin v.ctrl = 4'b0110; v.res = v.rs1 - b; end
      else begin v.ctrl = 4'b0010; v.res = v.rs1 + b; end
    end else if (v.aluop == 2'b10 && v.f3 == 3'd7) begin
      v.ctrl = 4'b0000; v.res = v.rs1 & b;
    end else if (v.aluop == 2'b10 && v.f3 == 3'd6) begin
      v.ctrl = 4'b0001; v.res = v.rs1 | b;
    end else if (v.aluop == 2'b10 && v.f3 == 3'd2) begin
      v.ctrl = 4'b0111; v.res = (v.rs1 < b) ? 32'd1 : 32'd0;
    end else begin
      // undecodable: ALU sits on code 0000, which is AND
      v.ctrl = 4'b0000; v.res = v.rs1 & b; v.ill = 1'b1;
    end
  endtask

  task automatic drive(input vec_t v);
    ALUOp = v.aluop; funct3 = v.f3; funct7_5 = v.f7; ALUSrc = v.src;
    rs1_data = v.rs1; rs2_data = v.rs2; imm = v.imm;
  endtask

  // Present v at a negedge and return #1 after the accepting edge.
  task automatic issue(input vec_t v);
    int n;
    @(negedge clock);
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      $display("FAIL accept never happened, aborting");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "accept timeout");
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    issue(v);
    @(negedge clock);
    chk("alu_control", {28'b0, alu_control}, {28'b0, v.ctrl});
    chk("alu_in1", alu_in1, v.rs1);
    chk("alu_in2", alu_in2, v.src ? v.imm : v.rs2);
    chk("out_valid_exec", {31'b0, out_valid}, 32'd0);
    @(negedge clock);
    chk("out_valid_done", {31'b0, out_valid}, 32'd1);
    chk("result", result, v.res);
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, v.br});
    chk("illegal", {31'b0, illegal}, {31'b0, v.ill});
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    exp_cnt++;
    @(negedge clock);
    chk("issued_count", {16'b0, issued_count}, exp_cnt[31:0] & 32'hFFFF);
    chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
  endtask

  vec_t tbl[13];
  vec_t v, va, vb;

  initial begin
    tbl[0]  = '{2'b10, 3'b000, 1'b0, 1'b1, 32'd5, 32'd0, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0, 4'b0110, 32'd0, 1'b1, 1'b0};
    tbl[2]  = '{2'b01, 3'b001, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0, 4'b0110, 32'd0, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 3'b111, 1'b1, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 4'b0000, 32'hF000, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 3'b000, 1'b0, 1'b0, 32'hA5, 32'h0F, 32'd0, 4'b0000, 32'h05, 1'b0, 1'b1};
    tbl[6]  = '{2'b10, 3'b110, 1'b0, 1'b0, 32'hF0, 32'h0F, 32'd0, 4'b0001, 32'hFF, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'd0, 4'b0111, 32'd1, 1'b0, 1'b0};
    tbl[8]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd10, 32'd99, 32'd3, 4'b0010, 32'd13, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 3'b010, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'd0, 4'b0000, 32'h0F, 1'b0, 1'b1};
    tbl[10] = '{2'b00, 3'b101, 1'b1, 1'b1, 32'd1, 32'd0, 32'hFFFF_FFFF, 4'b0010, 32'd0, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 3'b001, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 4'b0110, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[12] = '{2'b10, 3'b010, 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 4'b0111, 32'd0, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_alu_control", {28'b0, alu_control}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, out_valid, branch_taken, illegal}, 32'd0);
    chk("rst_count", {16'b0, issued_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      v.aluop = 2'($urandom_range(0, 3));
      v.f3    = 3'($urandom_range(0, 7));
      v.f7    = 1'($urandom_range(0, 1));
      v.src   = 1'($urandom_range(0, 1));
      v.rs1   = $urandom;
      v.rs2   = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
      v.imm   = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
      ref_model(v);
      run_op(v);
    end

    // Backpressure, then simultaneous complete + accept
    va = tbl[0];
    vb = tbl[3];
    issue(va);
    @(negedge clock);
    @(negedge clock);
    chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
    drive(vb);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
      chk("bp_result_held", result, va.res);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_count", {16'b0, issued_count}, exp_cnt[31:0] & 32'hFFFF);
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_follow", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1 begin out_ready = 1'b0; in_valid = 1'b0; end
    exp_cnt++;
    @(negedge clock);
    chk("b2b_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("b2b_ctrl", {28'b0, alu_control}, {28'b0, vb.ctrl});
    chk("b2b_count", {16'b0, issued_count}, exp_cnt[31:0] & 32'hFFFF);
    @(negedge clock);
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_result", result, vb.res);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    exp_cnt++;
    @(negedge clock);
    chk("b2b_count2", {16'b0, issued_count}, exp_cnt[31:0] & 32'hFFFF);

    // Reset pulsed during EXEC
    issue(tbl[4]);
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_ctrl", {28'b0, alu_control}, 32'd0);
    chk("mid_rst_in", alu_in1 | alu_in2, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", {29'b0, out_valid, branch_taken, illegal}, 32'd0);
    chk("mid_rst_count", {16'b0, issued_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("post_rst_no_valid", {31'b0, out_valid}, 32'd0);
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    end
    run_op(tbl[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
